data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter in front of the single-port data memory, sharing it between the load/store unit (port 0) and the debug/DMA port (port 1). Round-robin grant with an optional bounded lock for multi-beat sequences. Memory address, write data and strobes are muxed from the granted port. Read data is registered into a one-cycle-latency response per port.

## Interface
- `ADDR_W`, 5: address width; matches `` `RegAddrBus ``.
- `DATA_W`, 32: data width; matches `` `RegBus ``.
- `MAX_LOCK`, 4: maximum consecutive grants a locking port may hold (range 1..15).
- CLK  in  1  sole clock; all state updates on posedge.
- RSTn  in  1  reset, synchronous, active-low.
- req0 / req1  in  1  port request; level; held with its addr/we/wdata until gnt.
- we0 / we1  in  1  1 = write, 0 = read.
- lock0 / lock1  in  1  request to keep ownership on the following cycles.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data.
- gnt0 / gnt1  out  1  combinational accept; the access completes at the posedge ending this cycle.
- rvalid0 / rvalid1  out  1  registered read-response valid, one cycle.
- rdata0 / rdata1  out  DATA_W  registered read data; holds its last value when rvalid is low.
- mem_addr  out  ADDR_W  to memory addr.
- mem_din  out  DATA_W  to memory DIN.
- mem_WRn  out  1  to memory WRn; driven at `` `WriteEnable `` level only for a granted write, else the opposite level.
- mem_RDn  out  1  to memory RDn; driven at `` `ReadEnable `` level only for a granted read, else the opposite level.
- mem_dout  in  DATA_W  from memory DOUT; combinational read.

## Operation
- State: round-robin pointer `prio` (0 or 1), lock owner (none/0/1), 4-bit lock counter, response registers.
- Arbitration, no lock active:
  - Only one port requests: that port is granted.
  - Both request: port `prio` is granted.
- `prio` update after each grant: set to the non-granted port.
- Lock acquire: granted port has lock=1 and MAX_LOCK>1. That port becomes owner and the counter loads 1.
- While an owner is set:
  - Only the owner can be granted; the other port waits even if the owner is idle.
  - Each owner grant increments the counter.
- Lock release, checked at the posedge:
  - Owner drops lock, or owner is idle (req=0).
  - Or the counter reaches MAX_LOCK; the other port then gets the next grant if it is requesting.
  - On release, `prio` points to the non-owner.
- Exactly one of gnt0/gnt1 or neither; never both.
- mem_addr/mem_din follow the granted port. With no grant they hold port 0's values and both strobes are inactive.
- Read response: rvalidX=1 and rdataX=mem_dout registered at the posedge ending a granted read of port X.
- Writes produce no rvalid.
- Read-after-write to the same address on consecutive grants returns the new data, since the memory writes at that posedge.

## Timing
- Reset (RSTn=0 at posedge), next cycle:
  - gnt0/1=0, mem strobes inactive, rvalid0/1=0, rdata0/1=0.
  - prio=0, lock released, counter=0.
- gnt and strobes are forced inactive combinationally while RSTn is low.
- Grant latency: 0 cycles (same cycle as req) when uncontended.
- Read latency: rvalid one cycle after gnt.
- Throughput: one access per cycle. A port alone with req held high is granted every cycle.
- Contention without lock: strict alternation, so each port gets 1 in 2 cycles.
- Reset mid-lock: lock cleared and pending rvalid dropped. A read granted in the reset cycle produces no response.

## Test plan
- Reset: assert RSTn=0 with req0=req1=1 → gnt0=gnt1=0; after release the first grant goes to port 0 (prio=0).
- Write then read, port 0: write addr 3 = 0xDEADBEEF, next cycle read addr 3 → gnt0 both cycles; rvalid0=1 with rdata0=0xDEADBEEF one cycle after the read grant.
- Contention: req0=req1=1 held, all reads, 6 cycles → grants 0,1,0,1,0,1; each rvalid follows its grant by one cycle.
- Lock bound: MAX_LOCK=4, port 1 lock=1 with req1 held, req0 held → gnt1 on 4 consecutive cycles, then gnt0, then gnt1.
- Lock early release: port 0 locks, drops lock after 2 grants while req1=1 → gnt1 on the following cycle.
- Reset mid-lock: RSTn low in lock cycle 2 → no rvalid for that read; lock cleared; first grant after reset goes to port 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Shares the single-port data memory between the load/store unit (port 0)
//   and the debug/DMA port (port 1). Round-robin grant, with an optional
//   bounded lock that lets one port keep ownership for multi-beat sequences.
//   The memory address, write data and strobes come from the granted port.
//   Read data is registered into a one-cycle-latency response per port.
//
// Ports
//   CLK, RSTn               clock, synchronous active-low reset
//   reqN/weN/lockN          port request, write select, keep-ownership request
//   addrN/wdataN            port word address and write data
//   gntN                    combinational accept (access done at next posedge)
//   rvalidN/rdataN          registered read response (rdata holds when idle)
//   mem_addr/mem_din        to memory address / data-in
//   mem_WRn/mem_RDn         memory strobes (active only for a granted access)
//   mem_dout                combinational read data from memory
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 4
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_WRn,
   output logic              mem_RDn,
   input  logic [DATA_W-1:0] mem_dout
);

   // Memory strobe levels: both strobes are active-low.
   localparam logic WRITE_ENABLE = 1'b0;
   localparam logic READ_ENABLE  = 1'b0;

   // A bound of 1 means a lock could never outlast its first grant, so
   // locking is simply disabled in that case.
   localparam bit       LOCK_EN    = (MAX_LOCK > 1);
   localparam logic [3:0] MAX_LOCK_C = 4'(MAX_LOCK);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   owner_e            owner_q,  owner_d;
   logic              prio_q,   prio_d;
   logic [3:0]        cnt_q,    cnt_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              gnt0_c, gnt1_c;
   logic              gnt_any, we_sel;

   // Grant: the lock owner is exclusive; otherwise a lone requester wins and
   // contention is resolved by prio. Reset masks every grant.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (RSTn) begin
         case (owner_q)
            OWN_P0:  gnt0_c = req0;
            OWN_P1:  gnt1_c = req1;
            default: begin
               if (req0 && (!req1 || !prio_q)) gnt0_c = 1'b1;
               else if (req1)                  gnt1_c = 1'b1;
            end
         endcase
      end
   end

   // Pointer, lock owner and counter. Release is judged on this cycle's
   // owner inputs and on the counter value after this cycle's grant.
   always_comb begin
      prio_d  = prio_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      if (gnt0_c) prio_d = 1'b1;
      if (gnt1_c) prio_d = 1'b0;
      case (owner_q)
         OWN_P0: begin
            if (gnt0_c) cnt_d = cnt_q + 4'd1;
            if (!req0 || !lock0 || (cnt_d >= MAX_LOCK_C)) begin
               owner_d = OWN_NONE;
               cnt_d   = 4'd0;
               prio_d  = 1'b1;
            end
         end
         OWN_P1: begin
            if (gnt1_c) cnt_d = cnt_q + 4'd1;
            if (!req1 || !lock1 || (cnt_d >= MAX_LOCK_C)) begin
               owner_d = OWN_NONE;
               cnt_d   = 4'd0;
               prio_d  = 1'b0;
            end
         end
         default: begin
            if (LOCK_EN && gnt0_c && lock0) begin
               owner_d = OWN_P0;
               cnt_d   = 4'd1;
            end else if (LOCK_EN && gnt1_c && lock1) begin
               owner_d = OWN_P1;
               cnt_d   = 4'd1;
            end
         end
      endcase
   end

   // Read responses capture mem_dout at the posedge ending a granted read.
   always_comb begin
      rvalid0_d = gnt0_c && !we0;
      rvalid1_d = gnt1_c && !we1;
      rdata0_d  = rvalid0_d ? mem_dout : rdata0_q;
      rdata1_d  = rvalid1_d ? mem_dout : rdata1_q;
   end

   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         owner_q   <= OWN_NONE;
         prio_q    <= 1'b0;
         cnt_q     <= 4'd0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         owner_q   <= owner_d;
         prio_q    <= prio_d;
         cnt_q     <= cnt_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
      end
   end

   // Memory side: port 0's address/data are presented whenever port 1 is
   // not granted, so the bus is stable while idle.
   assign gnt_any  = gnt0_c || gnt1_c;
   assign we_sel   = gnt1_c ? we1 : we0;
   assign mem_addr = gnt1_c ? addr1 : addr0;
   assign mem_din  = gnt1_c ? wdata1 : wdata0;
   assign mem_WRn  = (gnt_any &&  we_sel) ? WRITE_ENABLE : ~WRITE_ENABLE;
   assign mem_RDn  = (gnt_any && !we_sel) ? READ_ENABLE  : ~READ_ENABLE;

   assign gnt0    = gnt0_c;
   assign gnt1    = gnt1_c;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Directed stimulus for data_mem_arbiter against a small behavioural memory.
//   Each cycle the stimulus queues the expected grant/strobe pattern and any
//   expected read data; a negedge monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   logic              CLK = 1'b0;
   logic              RSTn;
   logic              req0, req1, we0, we1, lock0, lock1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, rvalid0, rvalid1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_din, mem_dout;
   logic              mem_WRn, mem_RDn;

   always #5 CLK = ~CLK;

   data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(4)) dut (
      .CLK(CLK), .RSTn(RSTn),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_WRn(mem_WRn), .mem_RDn(mem_RDn), .mem_dout(mem_dout)
   );

   // Behavioural memory: unwritten words read back as 32'hA500_00<addr>.
   logic [DATA_W-1:0] mem [32];
   logic [31:0]       wr_mask = '0;

   always @(posedge CLK) begin
      if (mem_WRn == 1'b0) begin
         mem[mem_addr]     <= mem_din;
         wr_mask[mem_addr] <= 1'b1;
      end
   end

   assign mem_dout = wr_mask[mem_addr] ? mem[mem_addr]
                                       : (32'hA500_0000 | {27'd0, mem_addr});

   typedef struct {
      logic [1:0] g;     // {gnt1, gnt0}
      logic       wrn;
      logic       rdn;
      logic       zero;  // response registers must read as reset values
   } exp_t;

   exp_t              exp_g  [$];
   logic [DATA_W-1:0] exp_r0 [$];
   logic [DATA_W-1:0] exp_r1 [$];
   int                checks = 0;
   int                errors = 0;
   logic              done   = 1'b0;

   always @(negedge CLK) begin
      exp_t              e;
      logic [DATA_W-1:0] d;
      if (exp_g.size() > 0) begin
         e = exp_g.pop_front();
         checks++;
         if ({gnt1, gnt0} !== e.g) begin
            errors++;
            $display("FAIL gnt @%0t: got %b expected %b", $time, {gnt1, gnt0}, e.g);
         end
         checks++;
         if ({mem_WRn, mem_RDn} !== {e.wrn, e.rdn}) begin
            errors++;
            $display("FAIL strobes @%0t: got WRn/RDn %b expected %b",
                     $time, {mem_WRn, mem_RDn}, {e.wrn, e.rdn});
         end
         if (e.zero) begin
            checks++;
            if ({rvalid1, rvalid0} !== 2'b00 || rdata0 !== '0 || rdata1 !== '0) begin
               errors++;
               $display("FAIL reset_resp @%0t: got rvalid %b rdata0 %h rdata1 %h expected 00/0/0",
                        $time, {rvalid1, rvalid0}, rdata0, rdata1);
            end
         end
      end
      if (rvalid0 === 1'b1) begin
         checks++;
         if (exp_r0.size() == 0) begin
            errors++;
            $display("FAIL rvalid0 @%0t: got unexpected response %h expected none", $time, rdata0);
         end else begin
            d = exp_r0.pop_front();
            if (rdata0 !== d) begin
               errors++;
               $display("FAIL rdata0 @%0t: got %h expected %h", $time, rdata0, d);
            end
         end
      end
      if (rvalid1 === 1'b1) begin
         checks++;
         if (exp_r1.size() == 0) begin
            errors++;
            $display("FAIL rvalid1 @%0t: got unexpected response %h expected none", $time, rdata1);
         end else begin
            d = exp_r1.pop_front();
            if (rdata1 !== d) begin
               errors++;
               $display("FAIL rdata1 @%0t: got %h expected %h", $time, rdata1, d);
            end
         end
      end
      if (done) begin
         checks++;
         if (exp_r0.size() != 0 || exp_r1.size() != 0 || exp_g.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d/%0d pending entries expected 0/0/0",
                     exp_r0.size(), exp_r1.size(), exp_g.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic ex(input logic [1:0] g, input logic wr, input logic zero);
      exp_t e;
      e.g    = g;
      e.wrn  = !((g != 2'b00) && wr);
      e.rdn  = !((g != 2'b00) && !wr);
      e.zero = zero;
      exp_g.push_back(e);
   endtask

   initial begin
      RSTn = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset with both ports requesting: nothing granted, strobes idle.
      tick(); req0 = 1; req1 = 1; addr0 = 5'd1; addr1 = 5'd2; ex(2'b00, 0, 0);
      tick(); ex(2'b00, 0, 1);

      // Contention, all reads: strict alternation starting at port 0.
      tick(); RSTn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 0) ex(2'b01, 0, 1); else ex(2'b01, 0, 0);
         exp_r0.push_back(32'hA500_0001);
         tick();
         ex(2'b10, 0, 0); exp_r1.push_back(32'hA500_0002);
         tick();
      end
      req0 = 0; req1 = 0; ex(2'b00, 0, 0);

      // Write then read, port 0, same address on consecutive grants.
      tick(); req0 = 1; we0 = 1; addr0 = 5'd3; wdata0 = 32'hDEAD_BEEF; ex(2'b01, 1, 0);
      tick(); we0 = 0; ex(2'b01, 0, 0); exp_r0.push_back(32'hDEAD_BEEF);
      tick(); req0 = 0; ex(2'b00, 0, 0);

      // Lock bound: port 1 holds for 4 grants, then port 0, then port 1.
      tick(); req0 = 1; req1 = 1; lock1 = 1; addr0 = 5'd4; addr1 = 5'd6;
      for (int i = 0; i < 4; i++) begin
         ex(2'b10, 0, 0); exp_r1.push_back(32'hA500_0006);
         tick();
      end
      ex(2'b01, 0, 0); exp_r0.push_back(32'hA500_0004);
      tick(); ex(2'b10, 0, 0); exp_r1.push_back(32'hA500_0006);
      tick(); req0 = 0; req1 = 0; lock1 = 0; ex(2'b00, 0, 0);

      // Early release: port 0 locks, drops lock on its third access.
      tick(); req0 = 1; lock0 = 1; req1 = 1; addr0 = 5'd8; addr1 = 5'd10;
      ex(2'b01, 0, 0); exp_r0.push_back(32'hA500_0008);
      tick(); ex(2'b01, 0, 0); exp_r0.push_back(32'hA500_0008);
      tick(); lock0 = 0; ex(2'b01, 0, 0); exp_r0.push_back(32'hA500_0008);
      tick(); ex(2'b10, 0, 0); exp_r1.push_back(32'hA500_000A);
      tick(); ex(2'b01, 0, 0); exp_r0.push_back(32'hA500_0008);
      tick(); req0 = 0; req1 = 0; ex(2'b00, 0, 0);

      // Reset mid-lock: the port 1 lock is lost and port 0 wins afterwards.
      tick(); req1 = 1; lock1 = 1; addr1 = 5'd7; ex(2'b10, 0, 0);
      exp_r1.push_back(32'hA500_0007);
      tick(); RSTn = 1'b0; req0 = 1; addr0 = 5'd9; ex(2'b00, 0, 0);
      tick(); RSTn = 1'b1; ex(2'b01, 0, 1); exp_r0.push_back(32'hA500_0009);
      tick(); ex(2'b10, 0, 0); exp_r1.push_back(32'hA500_0007);
      tick(); req0 = 0; req1 = 0; lock1 = 0; ex(2'b00, 0, 0);

      tick(); ex(2'b00, 0, 0);
      tick(); done = 1'b1;
   end

endmodule
